// File: rtl/input_loader.sv
// rtl/input_loader.sv - dual-channel A/X matrix buffer loader; optional LOADER_ERR_EN adds load_err
module input_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_load_en,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [AW-1:0]     a_raddr,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [AW-1:0]     x_raddr,
  output logic [DATA_W-1:0] x_rdata,
  output logic              aload_done,
  output logic              xload_done
`ifdef LOADER_ERR_EN
  ,
  output logic              load_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t            a_state, a_next;
  state_t            x_state, x_next;
  logic [AW-1:0]     a_cnt, x_cnt;
  logic              a_xfer, x_xfer;
  logic [DATA_W-1:0] a_buf [DEPTH];
  logic [DATA_W-1:0] x_buf [DEPTH];

  assign a_xfer  = a_valid && a_ready;
  assign x_xfer  = x_valid && x_ready;
  assign a_rdata = a_buf[a_raddr];
  assign x_rdata = x_buf[x_raddr];

  // A channel state register
  always_ff @(posedge clk) begin
    if (rst) a_state <= S_IDLE;
    else     a_state <= a_next;
  end

  // A channel next state and handshake outputs; ready depends on state only
  always_comb begin
    a_next     = a_state;
    a_ready    = 1'b0;
    aload_done = 1'b0;
    case (a_state)
      S_IDLE: if (input_load_en) a_next = S_LOAD;
      S_LOAD: begin
        a_ready = 1'b1;
        if (!input_load_en)                  a_next = S_IDLE;
        else if (a_valid && a_cnt == LAST)   a_next = S_DONE;
      end
      S_DONE: begin
        aload_done = 1'b1;
        if (!input_load_en) a_next = S_IDLE;
      end
      default: a_next = S_IDLE;
    endcase
  end

  // A element counter: held at zero outside LOAD so every load starts at element 0
  always_ff @(posedge clk) begin
    if (rst || a_state != S_LOAD || !input_load_en) a_cnt <= '0;
    else if (a_xfer)                                a_cnt <= a_cnt + 1'b1;
  end

  // A buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (a_xfer) a_buf[a_cnt] <= a_data;
  end

  // X channel state register
  always_ff @(posedge clk) begin
    if (rst) x_state <= S_IDLE;
    else     x_state <= x_next;
  end

  // X channel next state and handshake outputs; ready depends on state only
  always_comb begin
    x_next     = x_state;
    x_ready    = 1'b0;
    xload_done = 1'b0;
    case (x_state)
      S_IDLE: if (input_load_en) x_next = S_LOAD;
      S_LOAD: begin
        x_ready = 1'b1;
        if (!input_load_en)                  x_next = S_IDLE;
        else if (x_valid && x_cnt == LAST)   x_next = S_DONE;
      end
      S_DONE: begin
        xload_done = 1'b1;
        if (!input_load_en) x_next = S_IDLE;
      end
      default: x_next = S_IDLE;
    endcase
  end

  // X element counter: held at zero outside LOAD so every load starts at element 0
  always_ff @(posedge clk) begin
    if (rst || x_state != S_LOAD || !input_load_en) x_cnt <= '0;
    else if (x_xfer)                                x_cnt <= x_cnt + 1'b1;
  end

  // X buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (x_xfer) x_buf[x_cnt] <= x_data;
  end

`ifdef LOADER_ERR_EN
  logic en_q;

  // Sticky flag for stream data offered outside a load phase; cleared when a new load begins
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      en_q <= input_load_en;
      if (input_load_en && !en_q)                   load_err <= 1'b0;
      else if ((a_valid || x_valid) && !input_load_en) load_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - randomized self-checking bench for input_loader (LOADER_ERR_EN optional)
module tb_input_loader;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_load_en;
  logic [DW-1:0] a_data, x_data;
  logic          a_valid, x_valid;
  logic          a_ready, x_ready;
  logic [AW-1:0] a_raddr, x_raddr;
  logic [DW-1:0] a_rdata, x_rdata;
  logic          aload_done, xload_done;
`ifdef LOADER_ERR_EN
  logic          load_err;
`endif

  int passed = 0;
  int total  = 0;

  // Reference buffers: what each buffer entry must hold, and whether it has ever been written
  logic [DW-1:0] exp_a [DEPTH];
  logic [DW-1:0] exp_x [DEPTH];
  bit            known_a [DEPTH];
  bit            known_x [DEPTH];
  int            done_cyc_a, done_cyc_x;

  input_loader #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_load_en (input_load_en),
    .a_data        (a_data),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .x_data        (x_data),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .a_raddr       (a_raddr),
    .a_rdata       (a_rdata),
    .x_raddr       (x_raddr),
    .x_rdata       (x_rdata),
    .aload_done    (aload_done),
    .xload_done    (xload_done)
`ifdef LOADER_ERR_EN
    ,
    .load_err      (load_err)
`endif
  );

  always #5 clk = ~clk;

  // One load phase driven at negedges. The model is a per-channel element count:
  // ready is expected while fewer than DEPTH elements have been taken, done once all are.
  // stop_mode 1 drops input_load_en, 2 pulses rst, when A has taken stop_at elements.
  task automatic run_load(input int gap_a, input int gap_x, input bit seq,
                          input int base_a, input int base_x,
                          input int stop_mode, input int stop_at, input int hold);
    int cnt_a = 0, cnt_x = 0, cyc = 0, held = 0;
    bit started = 0;
    bit er_a, er_x, ed_a, ed_x, va, vx;
    logic [DW-1:0] da, dx;
    int ia, ix;
    done_cyc_a = -1;
    done_cyc_x = -1;
    forever begin
      @(negedge clk);
      er_a = started && cnt_a < DEPTH;
      er_x = started && cnt_x < DEPTH;
      ed_a = started && cnt_a == DEPTH;
      ed_x = started && cnt_x == DEPTH;
      total++; if (a_ready !== er_a) $display("FAIL a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, er_a); else passed++;
      total++; if (x_ready !== er_x) $display("FAIL x_ready cyc=%0d got=%b exp=%b", cyc, x_ready, er_x); else passed++;
      total++; if (aload_done !== ed_a) $display("FAIL aload_done cyc=%0d got=%b exp=%b", cyc, aload_done, ed_a); else passed++;
      total++; if (xload_done !== ed_x) $display("FAIL xload_done cyc=%0d got=%b exp=%b", cyc, xload_done, ed_x); else passed++;
      if (aload_done === 1'b1 && done_cyc_a < 0) done_cyc_a = cyc;
      if (xload_done === 1'b1 && done_cyc_x < 0) done_cyc_x = cyc;
      if (ed_a && ed_x) held++;

      if (stop_mode != 0 && started && cnt_a == stop_at) begin
        a_valid = 1'b0;
        x_valid = 1'b0;
        if (stop_mode == 1) input_load_en = 1'b0;
        else                rst = 1'b1;
        @(negedge clk);
        total++; if (a_ready !== 1'b0) $display("FAIL stop_a_ready got=%b exp=0", a_ready); else passed++;
        total++; if (x_ready !== 1'b0) $display("FAIL stop_x_ready got=%b exp=0", x_ready); else passed++;
        total++; if (aload_done !== 1'b0) $display("FAIL stop_aload_done got=%b exp=0", aload_done); else passed++;
        total++; if (xload_done !== 1'b0) $display("FAIL stop_xload_done got=%b exp=0", xload_done); else passed++;
        rst = 1'b0;
        input_load_en = 1'b0;
        @(negedge clk);
        return;
      end

      if (held > hold) begin
        input_load_en = 1'b0;
        a_valid = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        total++; if (aload_done !== 1'b0) $display("FAIL exit_aload_done got=%b exp=0", aload_done); else passed++;
        total++; if (xload_done !== 1'b0) $display("FAIL exit_xload_done got=%b exp=0", xload_done); else passed++;
        // sweep buffers after the load phase, one address per cycle
        for (int i = 0; i < DEPTH; i++) begin
          a_raddr = AW'(i);
          x_raddr = AW'(i);
          #1;
          if (known_a[i]) begin
            total++; if (a_rdata !== exp_a[i]) $display("FAIL a_buf[%0d] got=%0d exp=%0d", i, a_rdata, exp_a[i]); else passed++;
          end
          if (known_x[i]) begin
            total++; if (x_rdata !== exp_x[i]) $display("FAIL x_buf[%0d] got=%0d exp=%0d", i, x_rdata, exp_x[i]); else passed++;
          end
          @(negedge clk);
        end
        return;
      end

      if (cyc > 600) begin
        total++;
        $display("FAIL load_timeout cnt_a=%0d cnt_x=%0d exp=%0d", cnt_a, cnt_x, DEPTH);
        input_load_en = 1'b0;
        a_valid = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        return;
      end

      input_load_en = 1'b1;
      va = ($urandom_range(0, 99) >= gap_a);
      vx = ($urandom_range(0, 99) >= gap_x);
      da = seq ? DW'(base_a + cnt_a) : DW'($urandom);
      dx = seq ? DW'(base_x + cnt_x) : DW'($urandom);
      a_valid = va;
      a_data  = da;
      x_valid = vx;
      x_data  = dx;
      ia = cnt_a % DEPTH;
      ix = cnt_x % DEPTH;
      a_raddr = AW'(ia);
      x_raddr = AW'(ix);
      #1;
      // the entry about to be written still reads its previous contents
      if (known_a[ia]) begin
        total++; if (a_rdata !== exp_a[ia]) $display("FAIL a_read_old[%0d] got=%0d exp=%0d", ia, a_rdata, exp_a[ia]); else passed++;
      end
      if (known_x[ix]) begin
        total++; if (x_rdata !== exp_x[ix]) $display("FAIL x_read_old[%0d] got=%0d exp=%0d", ix, x_rdata, exp_x[ix]); else passed++;
      end
      if (er_a && va) begin exp_a[cnt_a] = da; known_a[cnt_a] = 1'b1; cnt_a++; end
      if (er_x && vx) begin exp_x[cnt_x] = dx; known_x[cnt_x] = 1'b1; cnt_x++; end
      started = 1'b1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    input_load_en = 1'b0;
    a_valid = 1'b0;
    x_valid = 1'b0;
    a_data = '0;
    x_data = '0;
    a_raddr = '0;
    x_raddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got=%b exp=0", a_ready); else passed++;
    total++; if (x_ready !== 1'b0) $display("FAIL reset_x_ready got=%b exp=0", x_ready); else passed++;
    total++; if (aload_done !== 1'b0) $display("FAIL reset_aload_done got=%b exp=0", aload_done); else passed++;
    total++; if (xload_done !== 1'b0) $display("FAIL reset_xload_done got=%b exp=0", xload_done); else passed++;
`ifdef LOADER_ERR_EN
    total++; if (load_err !== 1'b0) $display("FAIL reset_load_err got=%b exp=0", load_err); else passed++;
`endif
  endtask

  task automatic test_sequential_load();
    run_load(0, 0, 1'b1, 0, 32, 0, 0, 0);
  endtask

  task automatic test_a_gaps();
    run_load(40, 0, 1'b0, 0, 0, 0, 0, 0);
    total++;
    if (!(done_cyc_x >= 0 && done_cyc_a > done_cyc_x))
      $display("FAIL done_order got_a=%0d got_x=%0d exp=x_first", done_cyc_a, done_cyc_x);
    else passed++;
  endtask

  task automatic test_abort();
    run_load(0, 30, 1'b0, 0, 0, 1, 10, 0);
    run_load(20, 20, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    run_load(10, 10, 1'b0, 0, 0, 2, 20, 0);
    run_load(0, 0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hold_after_done();
    run_load(0, 0, 1'b0, 0, 0, 0, 0, 6);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) run_load(25, 25, 1'b0, 0, 0, 0, 0, 1);
  endtask

`ifdef LOADER_ERR_EN
  task automatic test_load_err();
    @(negedge clk);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    total++; if (load_err !== 1'b1) $display("FAIL load_err_set got=%b exp=1", load_err); else passed++;
    repeat (3) @(negedge clk);
    total++; if (load_err !== 1'b1) $display("FAIL load_err_sticky got=%b exp=1", load_err); else passed++;
    input_load_en = 1'b1;
    @(negedge clk);
    total++; if (load_err !== 1'b0) $display("FAIL load_err_clear got=%b exp=0", load_err); else passed++;
    input_load_en = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sequential_load();
    test_a_gaps();
    test_abort();
    test_reset_mid_load();
    test_hold_after_done();
    test_back_to_back();
`ifdef LOADER_ERR_EN
    test_load_err();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_loader.md
INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of every matrix element.
REQ-002 Parameter DEPTH, default 32: elements per matrix (4 columns x 8 products); AW = clog2(DEPTH) = 5.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 input_load_en  input  1  load request from controller, high for the whole load phase.
REQ-006 a_data  input  DATA_W  A-matrix element stream.
REQ-007 a_valid  input  1  a_data valid.
REQ-008 a_ready  output  1  loader accepts a_data.
REQ-009 x_data  input  DATA_W  X-matrix element stream.
REQ-010 x_valid  input  1  x_data valid.
REQ-011 x_ready  output  1  loader accepts x_data.
REQ-012 a_raddr  input  AW  ALU read address into A buffer.
REQ-013 a_rdata  output  DATA_W  A buffer contents at a_raddr.
REQ-014 x_raddr  input  AW  ALU read address into X buffer.
REQ-015 x_rdata  output  DATA_W  X buffer contents at x_raddr.
REQ-016 aload_done  output  1  A buffer fully loaded.
REQ-017 xload_done  output  1  X buffer fully loaded.

Function
REQ-018 Each channel (A, X) shall run an independent FSM with states IDLE, LOAD, DONE and its own AW-bit element counter.
REQ-019 IDLE: ready=0, done=0; input_load_en=1 shall move the channel to LOAD next cycle with counter cleared to 0.
REQ-020 LOAD: ready=1 (decoded from state only, not from valid); a transfer occurs in any cycle with valid=1 and ready=1.
REQ-021 Each transfer shall write data into buffer[counter] and increment the counter by 1.
REQ-022 The transfer with counter = DEPTH-1 shall move the channel to DONE next cycle; counter shall not wrap into a 33rd write.
REQ-023 DONE: done=1, ready=0, buffer frozen; channel stays in DONE while input_load_en=1 and returns to IDLE the cycle after input_load_en=0.
REQ-024 input_load_en=0 while in LOAD shall abort: next state IDLE, counter cleared, done never asserted; already-written entries remain.
REQ-025 Done shall rise exactly one cycle after the final transfer; A and X channels may finish in either order or in the same cycle.
REQ-026 valid while ready=0 shall be ignored (no write, no counter change).
REQ-027 a_rdata/x_rdata shall be combinational reads of the register buffers; a read of the address being written in the same cycle returns the old value.
REQ-028 Buffer contents shall persist through IDLE and DONE so the ALU can read them after input_load_en falls.

Reset
REQ-029 rst=1 at a rising edge shall force both FSMs to IDLE and both counters to 0, from any state including mid-LOAD.
REQ-030 After reset: a_ready=0, x_ready=0, aload_done=0, xload_done=0; buffer contents are not reset (read data undefined until loaded).

Configuration
REQ-031 Macro LOADER_ERR_EN defined: an extra output load_err (1 bit) shall exist, cleared by rst, set sticky when a_valid or x_valid is 1 while input_load_en=0, and cleared on the cycle input_load_en rises.
REQ-032 LOADER_ERR_EN undefined: no load_err port and no error logic; all other behaviour identical.

Verification
REQ-033 Reset, raise input_load_en, stream A=0..31 and X=32..63 with valid held high -> ready rises 1 cycle after enable, both done rise 1 cycle after 32nd transfer, a_rdata[5]=5, x_rdata[31]=63.
REQ-034 Random valid gaps on A only, X continuous -> xload_done rises first, aload_done later; no dropped or duplicated element in either buffer.
REQ-035 Drop input_load_en after 10 A transfers, re-raise, stream 32 new values -> counter restarts at 0, aload_done only after full 32, buffer[0..31] holds new values.
REQ-036 Assert rst during LOAD at element 20 -> next cycle ready=0, done=0; subsequent load completes normally from element 0.
REQ-037 Hold valid after DONE with input_load_en high -> ready=0, no writes, buffer unchanged; with LOADER_ERR_EN, valid while input_load_en=0 -> load_err=1 until next input_load_en rise.
